// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam bit ORDER_MSB_FIRST = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;

  // Bit counter width; the counter only needs to reach width-1.
  function automatic int unsigned bitcnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Accepts a WIDTH-bit word over valid/ready and emits it one bit per cycle,
// with a frame qualifier and an end-of-word pulse; back-to-back words have no gap.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             sdata,
  output logic             sframe,
  output logic             done
);

  localparam int unsigned      CNT_W    = bitcnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam bit               MSB_MODE = (MSB_FIRST == ORDER_MSB_FIRST);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic             sdata_q, sdata_d;
  logic             sframe_q, sframe_d;
  logic             done_q, done_d;
  logic             last_bit;
  logic             accept;

  function automatic logic out_bit(input logic [WIDTH-1:0] s);
    return MSB_MODE ? s[WIDTH-1] : s[0];
  endfunction

  assign last_bit  = (state_q == ST_SHIFT) && (bitcnt_q == LAST_BIT);
  assign ready_out = (state_q == ST_IDLE) || last_bit;
  assign accept    = valid_in && ready_out;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_SHIFT;
          shreg_d  = data_in;
          bitcnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          if (accept) begin
            shreg_d  = data_in;
            bitcnt_d = '0;
          end else begin
            state_d  = ST_IDLE;
            shreg_d  = '0;
            bitcnt_d = '0;
          end
        end else begin
          shreg_d  = MSB_MODE ? (shreg_q << 1) : (shreg_q >> 1);
          bitcnt_d = bitcnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        shreg_d  = '0;
        bitcnt_d = '0;
      end
    endcase

    // Outputs are registered, so they are derived from the next-state values.
    sframe_d = (state_d == ST_SHIFT);
    sdata_d  = sframe_d ? out_bit(shreg_d) : IDLE_LEVEL;
    done_d   = sframe_d && (bitcnt_d == LAST_BIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      sdata_q  <= IDLE_LEVEL;
      sframe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      sdata_q  <= sdata_d;
      sframe_q <= sframe_d;
      done_q   <= done_d;
    end
  end

  assign sdata  = sdata_q;
  assign sframe = sframe_q;
  assign done   = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances against a queue model.
module tb_piso_serializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         valid_in = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         m_ready, m_sdata, m_sframe, m_done;
  logic         l_ready, l_sdata, l_sframe, l_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(m_ready), .sdata(m_sdata), .sframe(m_sframe), .done(m_done)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(l_ready), .sdata(l_sdata), .sframe(l_sframe), .done(l_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: queue of bits still to appear on sdata, head = bit visible this cycle.
  bit mq[$];
  bit lq[$];
  bit acc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      lq.delete();
    end else begin
      acc = valid_in && (mq.size() <= 1);
      if (mq.size() > 0) void'(mq.pop_front());
      if (lq.size() > 0) void'(lq.pop_front());
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          mq.push_back(data_in[W-1-i]);
          lq.push_back(data_in[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("msb_sdata",  m_sdata,  (mq.size() > 0) ? mq[0] : 1'b0);
    chk("msb_sframe", m_sframe, mq.size() > 0);
    chk("msb_done",   m_done,   mq.size() == 1);
    chk("msb_ready",  m_ready,  mq.size() <= 1);
    chk("lsb_sdata",  l_sdata,  (lq.size() > 0) ? lq[0] : 1'b0);
    chk("lsb_sframe", l_sframe, lq.size() > 0);
    chk("lsb_done",   l_done,   lq.size() == 1);
    chk("lsb_ready",  l_ready,  lq.size() <= 1);
  end

  task automatic send(input logic [W-1:0] w, input bit hold);
    bit ok;
    ok = 1'b0;
    data_in  = w;
    valid_in = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (m_ready) ok = 1'b1;
      @(posedge clk);
      #2;
    end
    chk("send_accept", ok, 1'b1);
    if (!hold) valid_in = 1'b0;
  endtask

  task automatic collect(input int n, input bit lsb, output logic [15:0] bits,
                         output int ndone, output int nready);
    bits = '0;
    ndone = 0;
    nready = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bits = {bits[14:0], lsb ? l_sdata : m_sdata};
      if (m_done) ndone++;
      if (m_ready) nready++;
    end
  endtask

  initial begin
    logic [15:0] bits;
    int nd, nr, c_a, c_b;

    // Reset held with valid asserted: nothing accepted, reset outputs.
    valid_in = 1'b1;
    data_in  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_sdata", m_sdata, 1'b0);
      chk("rst_sframe", m_sframe, 1'b0);
      chk("rst_done", m_done, 1'b0);
      chk("rst_ready", m_ready, 1'b1);
    end
    valid_in = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_sframe", m_sframe, 1'b0);

    // Single word.
    send(8'hA5, 1'b0);
    collect(8, 1'b0, bits, nd, nr);
    chk("single_bits", bits[7:0], 8'hA5);
    chk("single_done", nd, 1);
    @(negedge clk);
    chk("single_idle_sframe", m_sframe, 1'b0);
    chk("single_idle_sdata", m_sdata, 1'b0);

    // Back-to-back words with valid held.
    send(8'hA5, 1'b1);
    fork
      send(8'h3C, 1'b0);
      collect(16, 1'b0, bits, nd, nr);
    join
    chk("b2b_bits", bits, 16'hA53C);
    chk("b2b_done", nd, 2);
    chk("b2b_ready", nr, 2);
    repeat (2) @(negedge clk);

    // Stall: offer a word during bit 2, accepted on the bit-7 edge.
    send(8'hA5, 1'b0);
    c_a = cyc;
    repeat (2) begin @(posedge clk); #2; end
    data_in  = 8'hF0;
    valid_in = 1'b1;
    #1 chk("stall_ready", m_ready, 1'b0);
    send(8'hF0, 1'b0);
    c_b = cyc;
    chk("stall_gap", c_b - c_a, 8);
    collect(8, 1'b0, bits, nd, nr);
    chk("stall_bits", bits[7:0], 8'hF0);
    repeat (2) @(negedge clk);

    // Reset mid-word during bit 3.
    send(8'hFF, 1'b0);
    repeat (3) begin @(posedge clk); #2; end
    #1 reset = 1'b0;
    #1;
    chk("midrst_sdata", m_sdata, 1'b0);
    chk("midrst_sframe", m_sframe, 1'b0);
    chk("midrst_done", m_done, 1'b0);
    chk("midrst_ready", m_ready, 1'b1);
    repeat (2) @(negedge clk);
    data_in  = 8'h81;
    valid_in = 1'b1;
    reset    = 1'b1;
    @(posedge clk);
    #2 valid_in = 1'b0;
    chk("midrst_first_accept", m_sframe, 1'b1);
    @(posedge clk);
    #2;
    collect(7, 1'b0, bits, nd, nr);
    chk("midrst_bits", bits[6:0], 7'h01);
    repeat (2) @(negedge clk);

    // LSB-first instance.
    send(8'h01, 1'b0);
    collect(8, 1'b1, bits, nd, nr);
    chk("lsb_bits", bits[7:0], 8'h80);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
